uart_receiver: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) with a first-word-fall-through receive FIFO. It is the host-to-board counterpart of the TRNG's UART transmit path. It decodes command bytes arriving on the board's RXD pin in the `CLK` domain and offers them to downstream control logic through a pop interface. It also flags framing errors and FIFO overruns.

---
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 LSB-first serial receiver with a first-word-fall-through byte FIFO
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RXD,
    input  logic                     RE,
    output logic [7:0]               DOUT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FERR,
    output logic                     OVERRUN
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int SCW  = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    localparam logic [SCW-1:0] SC_HALF = SCW'(HALF - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t         state, state_n;
    logic           rx_meta, rxs;
    logic [SCW-1:0] sc, sc_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [7:0]     shreg, shreg_n;
    logic           push_req;
    logic           ferr_set;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count_n;
    logic           pop, push_ok, ovr_set;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            sc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            sc      <= sc_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        sc_n      = sc + SCW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                sc_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit
                if (sc == SC_HALF) begin
                    sc_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            DATA: begin
                if (sc == SC_LAST) begin
                    sc_n             = '0;
                    shreg_n[bit_idx] = rxs;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (sc == SC_LAST) begin
                    sc_n = '0;
                    if (rxs) begin
                        push_req = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            BREAK: begin
                sc_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot the push needs
    assign pop     = RE && !EMPTY;
    assign push_ok = push_req && (!FULL || pop);
    assign ovr_set = push_req && FULL && !pop;

    always_comb begin
        count_n = COUNT;
        if (push_ok && !pop)      count_n = COUNT + CW'(1);
        else if (pop && !push_ok) count_n = COUNT - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wptr] <= shreg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr    <= '0;
            rptr    <= '0;
            COUNT   <= '0;
            EMPTY   <= 1'b1;
            FULL    <= 1'b0;
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            COUNT   <= count_n;
            EMPTY   <= (count_n == '0);
            FULL    <= (count_n == CW'(DEPTH));
            FERR    <= ferr_set;
            OVERRUN <= ovr_set;
        end
    end

    assign DOUT = EMPTY ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed bench for uart_receiver against a queue model
module tb_uart_receiver;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;
    localparam int LAT   = 2 + HALF + 9 * CPB;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        bit         good;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       RE  = 1'b0;
    logic [7:0] DOUT;
    logic       EMPTY, FULL, FERR, OVERRUN;
    logic [2:0] COUNT;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ferr = 0, m_ovr = 0;
    int         cyc = 0;
    int         n_vec = 0, n_err = 0;
    int         ferr_seen = 0, ovr_seen = 0;
    int         last_s = 0;
    bit         rand_on = 0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .RE(RE),
        .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
        .FERR(FERR), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a byte queue plus the stop-sample cycle of every frame on the wire
    always @(negedge CLK) begin : model
        logic [14:0] act, exp;
        int          sz;
        bit          pop;
        ev_t         e;
        act = {DOUT, EMPTY, FULL, COUNT, FERR, OVERRUN};
        if (RST) begin
            chk("reset_outputs", int'(act), int'({8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}));
            mq.delete();
            evq.delete();
            m_ferr = 0;
            m_ovr  = 0;
        end else begin
            sz  = mq.size();
            exp = {(sz == 0) ? 8'h00 : mq[0], sz == 0, sz == DEPTH, 3'(sz), m_ferr, m_ovr};
            chk("cycle_outputs", int'(act), int'(exp));
            if (FERR)    ferr_seen++;
            if (OVERRUN) ovr_seen++;
            pop = RE && (sz > 0);
            if (pop) void'(mq.pop_front());
            m_ferr = 0;
            m_ovr  = 0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                if (!e.good)                   m_ferr = 1;
                else if (sz < DEPTH || pop)    mq.push_back(e.b);
                else                           m_ovr = 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Pin-level frame; returns at the clock edge just before the next bit slot
    task automatic send(input logic [7:0] b, input bit stopv);
        ev_t e;
        @(posedge CLK);
        #1;
        RXD    = 1'b0;
        e.cyc  = cyc + LAT;
        e.b    = b;
        e.good = stopv;
        evq.push_back(e);
        last_s = e.cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge CLK);
            #1 RXD = b[i];
        end
        repeat (CPB) @(posedge CLK);
        #1 RXD = stopv;
        repeat (CPB - 1) @(posedge CLK);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        chk(name, int'(DOUT), int'(exp));
        RE = 1'b1;
        idle(1);
        RE = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int f0, o0;
        logic [7:0] rb;
        idle(3);
        RST = 1'b0;
        idle(5);

        send(8'hA5, 1'b1);
        idle(1);
        chk("a5_dout", int'(DOUT), 8'hA5);
        chk("a5_count", int'(COUNT), 1);
        chk("a5_empty", int'(EMPTY), 0);
        RE = 1'b1;
        idle(1);
        RE = 1'b0;
        chk("a5_pop_empty", int'(EMPTY), 1);
        chk("a5_pop_count", int'(COUNT), 0);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        send(8'h80, 1'b1);
        idle(2);
        chk("b2b_full", int'(FULL), 1);
        chk("b2b_count", int'(COUNT), 4);
        pop_expect("b2b_pop0", 8'h00);
        pop_expect("b2b_pop1", 8'hFF);
        pop_expect("b2b_pop2", 8'h55);
        pop_expect("b2b_pop3", 8'h80);
        chk("b2b_no_ferr", ferr_seen, 0);

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        idle(2);
        chk("ovr_once", ovr_seen, 1);
        for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", 8'(i));
        chk("ovr_drained", int'(EMPTY), 1);

        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        o0 = ovr_seen;
        fork
            send(8'h05, 1'b1);
            begin
                @(posedge CLK);
                #2;
                while (cyc < last_s) begin
                    @(posedge CLK);
                    #1;
                end
                RE = 1'b1;
                @(posedge CLK);
                #1 RE = 1'b0;
            end
        join
        idle(2);
        chk("popS_no_ovr", ovr_seen, o0);
        chk("popS_count", int'(COUNT), 4);
        for (int i = 2; i <= 5; i++) pop_expect("popS_pop", 8'(i));

        f0 = ferr_seen;
        send(8'hA5, 1'b0);
        idle(40);
        RXD = 1'b1;
        idle(5);
        chk("brk_ferr_once", ferr_seen - f0, 1);
        chk("brk_no_push", int'(EMPTY), 1);
        send(8'h3C, 1'b1);
        idle(2);
        pop_expect("brk_after", 8'h3C);

        f0 = ferr_seen;
        @(posedge CLK);
        #1 RXD = 1'b0;
        idle(5);
        RXD = 1'b1;
        idle(30);
        chk("glitch_empty", int'(EMPTY), 1);
        chk("glitch_no_ferr", ferr_seen - f0, 0);

        send(8'h99, 1'b1);
        idle(2);
        fork
            send(8'hC3, 1'b1);
            begin
                idle(60);
                #2 RST = 1'b1;
                #1;
                chk("rst_async_empty", int'(EMPTY), 1);
                chk("rst_async_count", int'(COUNT), 0);
                chk("rst_async_dout", int'(DOUT), 0);
            end
        join
        idle(2);
        RST = 1'b0;
        idle(5);
        send(8'h7E, 1'b1);
        idle(2);
        pop_expect("rst_after", 8'h7E);
        chk("rst_after_empty", int'(EMPTY), 1);

        rand_on = 1;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    rb = 8'($urandom);
                    if ($urandom % 8 == 0) begin
                        send(rb, 1'b0);
                        idle(1 + $urandom_range(0, 30));
                        RXD = 1'b1;
                        idle(3);
                    end else begin
                        send(rb, 1'b1);
                        idle($urandom_range(0, 20));
                    end
                end
                idle(2 * CPB);
                rand_on = 0;
            end
            begin
                while (rand_on) begin
                    RE = ($urandom % 3 == 0);
                    idle(1);
                end
                RE = 1'b0;
            end
        join
        for (int i = 0; i < DEPTH + 2; i++) begin
            RE = !EMPTY;
            idle(1);
        end
        RE = 1'b0;
        idle(5);
        chk("final_empty", int'(EMPTY), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
